// File: rtl/pram_arbiter.sv
// pram_arbiter: round-robin arbiter sharing the single-port synchronous
// program RAM between NUM_REQ requesters (0 = fetch, 1 = microcode data,
// 2 = external loader). One access is granted per cycle, and read data
// returns one cycle after the grant, tagged to the winner.
// Optional macro PRAM_ARB_LOCK_EN adds req_lock: a granted requester that
// holds req_lock keeps exclusive ownership of the RAM for bursts.
module pram_arbiter #(
  parameter int NUM_REQ       = 3,
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16
) (
  input  logic                             clock,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_rw,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
`ifdef PRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]               req_lock,
`endif
  output logic [NUM_REQ-1:0]               grant,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_data,
  output logic                             ram_enable,
  output logic                             ram_rw,
  output logic [ADDRESS_WIDTH-1:0]         ram_address,
  output logic [DATA_WIDTH-1:0]            ram_data_in,
  input  logic [DATA_WIDTH-1:0]            ram_data_out,
  output logic                             busy
);

  localparam int PW = $clog2(NUM_REQ);

  logic [PW-1:0]      last_grant;
  logic [NUM_REQ-1:0] eligible;
  logic [PW-1:0]      winner;
  logic               found;
  logic               any_grant;
  logic [NUM_REQ-1:0] vld_p1;

`ifdef PRAM_ARB_LOCK_EN
  logic               locked;
  logic [PW-1:0]      lock_owner;
  logic [NUM_REQ-1:0] owner_mask;

  // While a lock is held only the owner may compete
  always_comb begin
    owner_mask             = '0;
    owner_mask[lock_owner] = 1'b1;
    eligible               = locked ? (req & owner_mask) : req;
  end
`else
  // Pure round-robin: every asserted request is eligible
  always_comb begin
    eligible = req;
  end
`endif

  // Search eligible requesters starting just after the last winner, with wrap-around
  always_comb begin
    logic [PW:0] cand;
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last_grant} + (PW+1)'(k);
      if (cand >= (PW+1)'(NUM_REQ)) begin
        cand = cand - (PW+1)'(NUM_REQ);
      end
      if (!found && eligible[cand[PW-1:0]]) begin
        found  = 1'b1;
        winner = cand[PW-1:0];
      end
    end
  end

  // Drive the one-hot grant and mux the winner's request onto the RAM port
  always_comb begin
    any_grant   = found & reset_n;
    grant       = '0;
    ram_enable  = any_grant;
    ram_rw      = 1'b0;
    ram_address = '0;
    ram_data_in = '0;
    if (any_grant) begin
      grant[winner] = 1'b1;
      ram_rw        = req_rw[winner];
      ram_address   = req_address[int'(winner)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      ram_data_in   = req_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Stage p0 -> p1: record the last winner and flag a read response for next cycle
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= PW'(NUM_REQ-1);
      vld_p1     <= '0;
    end else begin
      if (any_grant) begin
        last_grant <= winner;
      end
      vld_p1 <= grant & ~req_rw;
    end
  end

`ifdef PRAM_ARB_LOCK_EN
  // Take the lock on a grant with req_lock; drop it when the owner lets go
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      locked     <= 1'b0;
      lock_owner <= '0;
    end else if (locked) begin
      if (!req[lock_owner] || (grant[lock_owner] && !req_lock[lock_owner])) begin
        locked <= 1'b0;
      end
    end else if (any_grant && req_lock[winner]) begin
      locked     <= 1'b1;
      lock_owner <= winner;
    end
  end
`endif

  assign rsp_valid = vld_p1;
  assign rsp_data  = ram_data_out;
  assign busy      = |req;

endmodule

// File: tb/tb_pram_arbiter.sv
// Bench for pram_arbiter: a behavioural RAM, a table of directed vectors,
// hand-written reset/lock sequences and randomized traffic against a
// reference model of the round-robin rules.
module tb_pram_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [2:0]  req, req_rw;
  logic [47:0] req_address, req_data;
`ifdef PRAM_ARB_LOCK_EN
  logic [2:0]  req_lock;
`endif
  logic [2:0]  grant, rsp_valid;
  logic [15:0] rsp_data;
  logic        ram_enable, ram_rw;
  logic [15:0] ram_address, ram_data_in, ram_data_out;
  logic        busy;

  int total = 0;
  int bad   = 0;

  pram_arbiter #(.NUM_REQ(3), .ADDRESS_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .req(req), .req_rw(req_rw), .req_address(req_address), .req_data(req_data),
`ifdef PRAM_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .grant(grant), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural single-port synchronous RAM, preloaded on the first edge
  logic [15:0] mem [256];
  logic        preloaded = 1'b0;
  always @(posedge clock) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(i * 16'h0101);
      mem[8'h04] <= 16'hA1B2;
      mem[8'h20] <= 16'h5000;
      mem[8'h21] <= 16'h5001;
      mem[8'h22] <= 16'h5002;
      preloaded  <= 1'b1;
    end else if (ram_enable) begin
      if (ram_rw) mem[ram_address[7:0]] <= ram_data_in;
      else        ram_data_out          <= mem[ram_address[7:0]];
    end
  end

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  rw;
    logic [47:0] addr;
    logic [47:0] wdata;
    logic [2:0]  exp_grant;
    logic [2:0]  exp_vld;
    logic [15:0] exp_data;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] r, input logic [2:0] rw, input logic [47:0] a,
                              input logic [47:0] d, input logic [2:0] g, input logic [2:0] v,
                              input logic [15:0] x);
    vec_t t;
    t.req = r; t.rw = rw; t.addr = a; t.wdata = d;
    t.exp_grant = g; t.exp_vld = v; t.exp_data = x;
    return t;
  endfunction

  vec_t        tbl [12];
  logic [15:0] model_mem [256];

  initial begin
    int          model_ptr;
    int          w;
    logic [2:0]  exp_vld;
    logic [15:0] exp_data;
    logic [2:0]  exp_grant;
    logic [15:0] a [3];
    logic [15:0] d [3];

    // Directed vectors; rsp columns refer to the grant of the previous row
    tbl[0]  = mk(3'b000, 3'b000, 48'h0,              48'h0,              3'b000, 3'b000, 16'h0);
    tbl[1]  = mk(3'b111, 3'b000, 48'h0022_0021_0020, 48'h0,              3'b001, 3'b000, 16'h0);
    tbl[2]  = mk(3'b111, 3'b000, 48'h0022_0021_0020, 48'h0,              3'b010, 3'b001, 16'h5000);
    tbl[3]  = mk(3'b111, 3'b000, 48'h0022_0021_0020, 48'h0,              3'b100, 3'b010, 16'h5001);
    tbl[4]  = mk(3'b111, 3'b000, 48'h0022_0021_0020, 48'h0,              3'b001, 3'b100, 16'h5002);
    tbl[5]  = mk(3'b111, 3'b000, 48'h0022_0021_0020, 48'h0,              3'b010, 3'b001, 16'h5000);
    tbl[6]  = mk(3'b111, 3'b000, 48'h0022_0021_0020, 48'h0,              3'b100, 3'b010, 16'h5001);
    tbl[7]  = mk(3'b001, 3'b000, 48'h0000_0000_0004, 48'h0,              3'b001, 3'b100, 16'h5002);
    tbl[8]  = mk(3'b000, 3'b000, 48'h0,              48'h0,              3'b000, 3'b001, 16'hA1B2);
    tbl[9]  = mk(3'b100, 3'b100, 48'h0010_0000_0000, 48'h1234_0000_0000, 3'b100, 3'b000, 16'h0);
    tbl[10] = mk(3'b001, 3'b000, 48'h0000_0000_0010, 48'h0,              3'b001, 3'b000, 16'h0);
    tbl[11] = mk(3'b000, 3'b000, 48'h0,              48'h0,              3'b000, 3'b001, 16'h1234);

    reset_n = 1'b0;
    req = 3'b111; req_rw = '0; req_address = '0; req_data = '0;
`ifdef PRAM_ARB_LOCK_EN
    req_lock = '0;
`endif
    step();
    step();
    check("grant_in_reset", 48'(grant), 48'h0);
    check("enable_in_reset", 48'(ram_enable), 48'h0);
    check("rsp_valid_in_reset", 48'(rsp_valid), 48'h0);
    req = 3'b000;
    #2 reset_n = 1'b1;
    #1;
    check("idle_grant", 48'(grant), 48'h0);
    check("idle_enable", 48'(ram_enable), 48'h0);
    check("idle_busy", 48'(busy), 48'h0);
    step();

    // Table-driven directed vectors
    for (int i = 0; i < 12; i++) begin
      req = tbl[i].req; req_rw = tbl[i].rw; req_address = tbl[i].addr; req_data = tbl[i].wdata;
      check($sformatf("tbl%0d_rsp_valid", i), 48'(rsp_valid), 48'(tbl[i].exp_vld));
      if (tbl[i].exp_vld != 3'b000) check($sformatf("tbl%0d_rsp_data", i), 48'(rsp_data), 48'(tbl[i].exp_data));
      #4;
      check($sformatf("tbl%0d_grant", i), 48'(grant), 48'(tbl[i].exp_grant));
      check($sformatf("tbl%0d_enable", i), 48'(ram_enable), 48'(|tbl[i].exp_grant));
      check($sformatf("tbl%0d_busy", i), 48'(busy), 48'(|tbl[i].req));
      step();
    end

    // Reset right after a read grant drops the response; requester 0 wins after release
    req = 3'b010; req_rw = 3'b000; req_address = 48'h0022_0021_0020;
    #4 check("pre_reset_grant", 48'(grant), 48'b010);
    step();
    reset_n = 1'b0;
    req = 3'b111;
    #1 check("reset_drop_rsp", 48'(rsp_valid), 48'h0);
    check("reset_grant", 48'(grant), 48'h0);
    check("reset_enable", 48'(ram_enable), 48'h0);
    step();
    check("reset_hold_rsp", 48'(rsp_valid), 48'h0);
    reset_n = 1'b1;
    #3 check("post_reset_grant", 48'(grant), 48'b001);
    check("post_reset_rsp", 48'(rsp_valid), 48'h0);
    step();
    req = 3'b000;
    check("post_reset_rsp_valid", 48'(rsp_valid), 48'b001);
    check("post_reset_rsp_data", 48'(rsp_data), 48'h5000);
    step();
    model_ptr = 0;

`ifdef PRAM_ARB_LOCK_EN
    // Requester 2 locks for a burst; releases on a grant with req_lock low
    req = 3'b010;
    #4 check("lock_setup_grant", 48'(grant), 48'b010);
    step();
    req = 3'b111; req_lock = 3'b100;
    #4 check("lock_grant1", 48'(grant), 48'b100);
    step();
    #4 check("lock_grant2", 48'(grant), 48'b100);
    step();
    req_lock = 3'b000;
    #4 check("lock_grant3", 48'(grant), 48'b100);
    step();
    #4 check("unlock_grant1", 48'(grant), 48'b001);
    step();
    #4 check("unlock_grant2", 48'(grant), 48'b010);
    step();
    req = 3'b000;
    step();
    model_ptr = 1;
`endif

    // Randomized traffic against a reference model
    for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
    exp_vld  = 3'b000;
    exp_data = 16'h0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req    = 3'($urandom);
      req_rw = 3'($urandom);
      for (int r = 0; r < 3; r++) begin
        a[r] = 16'($urandom_range(0, 15));
        d[r] = 16'($urandom);
      end
      req_address = {a[2], a[1], a[0]};
      req_data    = {d[2], d[1], d[0]};
      check("rnd_rsp_valid", 48'(rsp_valid), 48'(exp_vld));
      if (exp_vld != 3'b000) check("rnd_rsp_data", 48'(rsp_data), 48'(exp_data));
      w = -1;
      for (int k = 1; k <= 3; k++) begin
        if (w < 0 && req[(model_ptr + k) % 3]) w = (model_ptr + k) % 3;
      end
      exp_grant = (w < 0) ? 3'b000 : 3'(1 << w);
      #4;
      check("rnd_grant", 48'(grant), 48'(exp_grant));
      check("rnd_enable", 48'(ram_enable), 48'(w >= 0));
      check("rnd_busy", 48'(busy), 48'(req != 3'b000));
      exp_vld = 3'b000;
      if (w >= 0) begin
        check("rnd_address", 48'(ram_address), 48'(a[w]));
        check("rnd_rw", 48'(ram_rw), 48'(req_rw[w]));
        check("rnd_wdata", 48'(ram_data_in), 48'(d[w]));
        model_ptr = w;
        if (req_rw[w]) begin
          model_mem[a[w][7:0]] = d[w];
        end else begin
          exp_vld  = 3'(1 << w);
          exp_data = model_mem[a[w][7:0]];
        end
      end
      step();
    end
    check("final_rsp_valid", 48'(rsp_valid), 48'(exp_vld));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
